// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Command sequencer for the 8-bit calculator ALU. Commands are buffered in
//   a DEPTH-entry FIFO, issued one at a time to an external combinational ALU,
//   and each result (with carry) is registered and returned over a valid/ready
//   handshake. An accumulator optionally captures every executed result.
//
//   Handshakes (both directions): a transfer happens on a rising clk edge where
//   valid && ready are both 1. A producer holds valid and its payload stable
//   until that edge. cmd_ready = !full and does not depend on cmd_valid.
//   res_valid is a registered output and never depends on res_ready.
//
//   Optional feature macro: ALU_SEQ_TRAP_EN
//     defined   : opcodes 1101..1111 are trapped (alu_ctrl=0, acc unchanged,
//                 result 0 with res_err=1)
//     undefined : reserved opcodes go to the ALU like any other; res_err=0
//
// Ports
//   clk, rst_n                 clock (rising), async active-low reset
//   cmd_valid/ready, cmd_op, cmd_use_acc, cmd_x, cmd_y   command input
//   alu_ctrl, alu_x, alu_y     operands to the ALU (hold last EXEC values)
//   alu_out, alu_carry         ALU result, sampled only in EXEC
//   res_valid/ready, res_data, res_carry, res_err        result output
//   acc_q                      accumulator
//   clr_acc                    synchronous accumulator clear (wins over write)
//   busy                       FSM not IDLE or FIFO not empty
//   dbg_state                  FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter bit          ACC_WB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic       cmd_use_acc,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  output logic [3:0] alu_ctrl,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_err,
  output logic [7:0] acc_q,
  input  logic       clr_acc,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       use_acc;
    logic [7:0] x;
    logic [7:0] y;
  } cmd_t;

  // ---------------- command FIFO ----------------
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, empty;
  cmd_t          head;
  logic          head_trap;

  state_e        state_q;
  logic [3:0]    alu_ctrl_q;
  logic [7:0]    alu_x_q, alu_y_q;
  logic          trap_q;
  logic          res_valid_q, res_carry_q, res_err_q;
  logic [7:0]    res_data_q;
  logic [7:0]    acc_eff;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // The head leaves the FIFO only on the IDLE->EXEC transition.
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q];

`ifdef ALU_SEQ_TRAP_EN
  assign head_trap = (head.op >= 4'd13);
`else
  assign head_trap = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, use_acc: cmd_use_acc, x: cmd_x, y: cmd_y};
  end

  // A clear arriving in the issue cycle must be seen by a use_acc operand.
  assign acc_eff = clr_acc ? 8'h00 : acc_q;

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_ctrl_q  <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      trap_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            // Issue register doubles as the ALU operand drivers, so the
            // operands stay put after EXEC until the next issue.
            alu_ctrl_q <= head_trap ? 4'd0 : head.op;
            alu_x_q    <= head.use_acc ? acc_eff : head.x;
            alu_y_q    <= head.y;
            trap_q     <= head_trap;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= trap_q ? 8'h00 : alu_out;
          res_carry_q <= trap_q ? 1'b0  : alu_carry;
          res_err_q   <= trap_q;
          res_valid_q <= 1'b1;
          if (ACC_WB && !trap_q) acc_q <= alu_out;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed last so a clear overrides any write-back in the same cycle.
      if (clr_acc) acc_q <= 8'h00;
    end
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic       cmd_use_acc = 1'b0;
  logic [7:0] cmd_x = '0;
  logic [7:0] cmd_y = '0;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry, res_err;
  logic [7:0] acc_q;
  logic       clr_acc = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [7:0]  acc_m = 8'h00;
  logic [17:0] exp_q[$];   // {err, carry, data[7:0], acc[7:0]}

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_use_acc(cmd_use_acc), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_err(res_err), .acc_q(acc_q),
    .clr_acc(clr_acc), .busy(busy), .dbg_state(dbg_state)
  );

  // Behavioural calculator ALU: returns {carry, out}; reserved opcodes give 0.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] x,
                                        input logic [7:0] y);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, x} + {1'b0, y};
      4'd1:    r = {1'b0, x} - {1'b0, y};
      4'd2:    r = {1'b0, x & y};
      4'd3:    r = {1'b0, x | y};
      4'd4:    r = {1'b0, ~x};
      4'd5:    r = {1'b0, x ^ y};
      4'd6:    r = {x, 1'b0};
      4'd7:    r = {x[0], 1'b0, x[7:1]};
      4'd8:    r = {1'b0, x} + 9'd1;
      4'd9:    r = {1'b0, x} - 9'd1;
      4'd10:   r = {1'b0, y};
      4'd11:   r = {8'd0, (x < y)};
      4'd12:   r = {8'd0, (x == y)};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commands execute strictly in push order, so the expected accumulator can
  // be advanced here at acceptance time.
  task automatic model_push(input logic [3:0] op, input logic ua, input logic [7:0] x,
                            input logic [7:0] y);
    logic [7:0] xe;
    logic [8:0] r;
    logic       err;
    xe  = ua ? acc_m : x;
    r   = alu_fn(op, xe, y);
    err = 1'b0;
`ifdef ALU_SEQ_TRAP_EN
    if (op >= 4'd13) begin
      r   = 9'd0;
      err = 1'b1;
    end
`endif
    if (!err) acc_m = r[7:0];
    exp_q.push_back({err, r[8], r[7:0], acc_m});
  endtask

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic ua, input logic [7:0] x,
                      input logic [7:0] y);
    int w;
    cmd_valid = 1'b1; cmd_op = op; cmd_use_acc = ua; cmd_x = x; cmd_y = y;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      step();
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $error("FAIL push_timeout observed=cmd_ready_low expected=accept");
    end else begin
      model_push(op, ua, x, y);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int w;
    logic [17:0] e;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      @(negedge clk);
      while (!res_valid && w < 40) begin
        step();
        @(negedge clk);
        w++;
      end
      if (!res_valid) begin
        total++;
        bad++;
        $error("FAIL drain_timeout observed=no_result expected=result_%0d", i);
        break;
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_result observed=%0h expected=none", res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(e[15:8]));
        chk("res_carry", 32'(res_carry), 32'(e[16]));
        chk("res_err", 32'(res_err), 32'(e[17]));
        chk("acc_q", 32'(acc_q), 32'(e[7:0]));
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [17:0] e;

    // Reset state
    #2;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_carry", 32'(res_carry), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_acc", 32'(acc_q), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_alu_x", 32'(alu_x), 0);
    chk("rst_alu_y", 32'(alu_y), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: add 12+34, latency N+3
    push(4'd0, 1'b0, 8'h12, 8'h34);
    @(negedge clk);
    chk("t1_valid_n1", 32'(res_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("t1_exec_ctrl", 32'(alu_ctrl), 0);
    chk("t1_exec_x", 32'(alu_x), 32'h12);
    chk("t1_exec_y", 32'(alu_y), 32'h34);
    chk("t1_valid_n2", 32'(res_valid), 0);
    step();
    @(negedge clk);
    chk("t1_valid_n3", 32'(res_valid), 1);
    step();
    @(negedge clk);
    chk("t1_hold_valid", 32'(res_valid), 1);
    chk("t1_hold_data", 32'(res_data), 32'h46);
    step();
    drain(1);

    // 2: and with acc as x operand
    push(4'd2, 1'b1, 8'h99, 8'h0F);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t2_exec_x_from_acc", 32'(alu_x), 32'h46);
    chk("t2_exec_ctrl", 32'(alu_ctrl), 2);
    step();
    drain(1);

    // 3: backpressure, fill FIFO, rejected push, in-order drain
    for (int i = 0; i < 5; i++)
      push(4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    @(negedge clk);
    chk("t3_full_ready", 32'(cmd_ready), 0);
    chk("t3_full_busy", 32'(busy), 1);
    step();
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_use_acc = 1'b0; cmd_x = 8'hAA; cmd_y = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_reject_ready", 32'(cmd_ready), 0);
      step();
    end
    cmd_valid = 1'b0;
    drain(5);
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy), 0);
    chk("t3_idle_ready", 32'(cmd_ready), 1);
    step();

    // 4: clr_acc in the EXEC cycle beats the write-back
    push(4'd5, 1'b0, 8'hFF, 8'h0F);
    step();
    clr_acc = 1'b1;
    @(negedge clk);
    chk("t4_exec_ctrl", 32'(alu_ctrl), 5);
    step();
    clr_acc = 1'b0;
    e = exp_q.pop_back();
    e[7:0] = 8'h00;
    exp_q.push_back(e);
    acc_m = 8'h00;
    drain(1);

    // 5: reserved opcode, acc preloaded so a write-back is visible
    push(4'd0, 1'b0, 8'h20, 8'h01);
    drain(1);
    push(4'd14, 1'b0, 8'h5A, 8'h3C);
    @(negedge clk);
    step();
    @(negedge clk);
`ifdef ALU_SEQ_TRAP_EN
    chk("t5_exec_ctrl", 32'(alu_ctrl), 0);
`else
    chk("t5_exec_ctrl", 32'(alu_ctrl), 14);
`endif
    step();
    drain(1);

    // 6: reset while in RESP with two commands queued
    push(4'd0, 1'b0, 8'h01, 8'h02);
    push(4'd0, 1'b0, 8'h03, 8'h04);
    push(4'd0, 1'b0, 8'h05, 8'h06);
    @(negedge clk);
    chk("t6_pre_valid", 32'(res_valid), 1);
    chk("t6_pre_ready", 32'(cmd_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(res_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ready", 32'(cmd_ready), 1);
    chk("t6_rst_acc", 32'(acc_q), 0);
    chk("t6_rst_data", 32'(res_data), 0);
    chk("t6_rst_alu_x", 32'(alu_x), 0);
    exp_q.delete();
    acc_m = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Recovery after reset: acc restarted from zero
    push(4'd0, 1'b1, 8'hEE, 8'h07);
    drain(1);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
